time_display_mux: RTL and testbench

TIME_DISPLAY_MUX -- requirements
Module: time_display_mux

---
 rtl/time_display_mux.sv | 112 +++++++++++
 tb/tb_time_display_mux.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_display_mux.sv
`default_nettype none
// ============================================================================
//  Module      : time_display_mux
//  Description : 8-digit multiplexed 7-segment driver for a BCD stopwatch
//                time, with two display pages and a lap freeze.
//  Revision    : 1.0  initial release
// ============================================================================
module time_display_mux #(
    parameter int REFRESH_DIV = 12500
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic [35:0] count_i,
    input  logic        page_i,
    input  logic        lap_i,
    output logic [7:0]  anode_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);

    localparam int                    c_PRESC_W    = $clog2(REFRESH_DIV);
    localparam logic [c_PRESC_W-1:0]  c_PRESC_LAST = c_PRESC_W'(REFRESH_DIV - 1);
    localparam logic [6:0]            c_SEG_BLANK  = 7'h7F;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = 7'b0111111;
        endcase
    endfunction

    logic [c_PRESC_W-1:0] presc_q, presc_d;
    logic [2:0]           idx_q, idx_d;
    logic                 lap_prev_q, lap_prev_d;
    logic                 freeze_q, freeze_d;
    logic [35:0]          snap_q, snap_d;
    logic [7:0]           anode_q, anode_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;

    logic                 presc_wrap;
    logic [3:0]           nib_sel;
    logic [3:0]           digit;
    logic                 blank;
    logic                 dp_on;

    always_comb begin
        presc_wrap = (presc_q == c_PRESC_LAST);
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
        idx_d      = presc_wrap ? idx_q + 3'd1 : idx_q;
        lap_prev_d = lap_i;
        freeze_d   = freeze_q ^ (lap_i & ~lap_prev_q);
        snap_d     = freeze_q ? snap_q : count_i;

        // Page 0 drops ms1, so every position shows the nibble one above its index.
        nib_sel = {1'b0, idx_q} + {3'b000, ~page_i};
        digit   = snap_d[{nib_sel, 2'b00} +: 4];

        if (page_i) begin
            blank = (idx_q == 3'd7);
            dp_on = (idx_q == 3'd5) || (idx_q == 3'd3);
        end else begin
            blank = (idx_q == 3'd7) && (digit == 4'd0);
            dp_on = (idx_q == 3'd6) || (idx_q == 3'd4) || (idx_q == 3'd2);
        end
        if ((idx_q == 3'd0) && freeze_d) begin
            dp_on = 1'b1;
        end

        // Decoding the snapshot being written lets the first post-reset edge show it.
        anode_d = ~(8'b0000_0001 << idx_q);
        seg_d   = blank ? c_SEG_BLANK : seg_encode(digit);
        dp_d    = ~dp_on;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            presc_q    <= '0;
            idx_q      <= 3'd0;
            lap_prev_q <= 1'b0;
            freeze_q   <= 1'b0;
            snap_q     <= 36'd0;
            anode_q    <= 8'hFF;
            seg_q      <= c_SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            lap_prev_q <= lap_prev_d;
            freeze_q   <= freeze_d;
            snap_q     <= snap_d;
            anode_q    <= anode_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign anode_o = anode_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_time_display_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_display_mux
//  Description : Self-checking bench for time_display_mux (scan, pages, lap).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_time_display_mux;

    localparam int DIV = 4;

    logic        clk_i = 1'b0;
    logic        resetn_i = 1'b0;
    logic [35:0] count_i = 36'd0;
    logic        page_i = 1'b0;
    logic        lap_i = 1'b0;
    logic [7:0]  anode_o;
    logic [6:0]  seg_o;
    logic        dp_o;

    int n_checks = 0;
    int n_errors = 0;

    time_display_mux #(.REFRESH_DIV(DIV)) dut (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .count_i  (count_i),
        .page_i   (page_i),
        .lap_i    (lap_i),
        .anode_o  (anode_o),
        .seg_o    (seg_o),
        .dp_o     (dp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tab [16];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
                7'b0111111};
        return tab[d];
    endfunction

    function automatic int nib(input logic [35:0] v, input int k);
        return int'((v >> (4 * k)) & 36'hF);
    endfunction

    // ---------------- behavioural reference ----------------
    int          m_presc = 0;
    int          m_idx = 0;
    bit          m_freeze = 0;
    bit          m_lap_prev = 0;
    bit          m_valid = 0;
    logic [35:0] m_snap = 36'd0;
    logic [7:0]  e_anode;
    logic [6:0]  e_seg;
    logic        e_dp;

    initial forever begin
        bit          nf;
        logic [35:0] ns;
        bit          dp;
        @(posedge clk_i);
        if (resetn_i) begin
            nf = m_freeze ^ (lap_i && !m_lap_prev);
            ns = m_freeze ? m_snap : count_i;
            e_anode = 8'hFF;
            e_anode[m_idx] = 1'b0;
            if (page_i == 1'b0) begin
                dp    = (m_idx == 6 || m_idx == 4 || m_idx == 2);
                e_seg = (m_idx == 7 && nib(ns, 8) == 0) ? 7'h7F : seg_of(nib(ns, m_idx + 1));
            end else begin
                dp    = (m_idx == 5 || m_idx == 3);
                e_seg = (m_idx == 7) ? 7'h7F : seg_of(nib(ns, m_idx));
            end
            if (m_idx == 0 && nf) dp = 1;
            e_dp = !dp;
            m_presc = m_presc + 1;
            if (m_presc == DIV) begin
                m_presc = 0;
                m_idx   = (m_idx + 1) % 8;
            end
            m_freeze   = nf;
            m_snap     = ns;
            m_lap_prev = lap_i;
            m_valid    = 1;
        end
    end

    initial forever begin
        @(negedge clk_i);
        if (!resetn_i) begin
            chk("rst_anode", 32'(anode_o), 32'hFF);
            chk("rst_seg", 32'(seg_o), 32'h7F);
            chk("rst_dp", 32'(dp_o), 32'h1);
            m_presc = 0; m_idx = 0; m_freeze = 0; m_lap_prev = 0;
            m_snap = 36'd0; m_valid = 0;
        end else if (m_valid) begin
            chk("anode", 32'(anode_o), 32'(e_anode));
            chk("seg", 32'(seg_o), 32'(e_seg));
            chk("dp", 32'(dp_o), 32'(e_dp));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
        #1;
    endtask

    task automatic wait_anode(input logic [7:0] target);
        bit hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk_i);
            if (anode_o == target) hit = 1;
        end
        if (!hit) chk("wait_anode_timeout", 32'(anode_o), 32'(target));
    endtask

    task automatic pin(input string name, input logic [7:0] an, input logic [6:0] sg, input logic d);
        wait_anode(an);
        chk({name, "_seg"}, 32'(seg_o), 32'(sg));
        chk({name, "_dp"}, 32'(dp_o), 32'(d));
    endtask

    task automatic pulse_lap;
        lap_i = 1'b1;
        tick(1);
        lap_i = 1'b0;
    endtask

    initial begin
        tick(3);
        resetn_i = 1'b1;

        // page 0 scan of 1..8
        count_i = 36'h123456789;
        pin("p0_idx7", 8'h7F, 7'b1111001, 1'b1);
        pin("p0_idx6", 8'hBF, 7'b0100100, 1'b0);
        pin("p0_idx2", 8'hFB, 7'b0000010, 1'b0);
        pin("p0_idx0", 8'hFE, 7'b0000000, 1'b1);

        // page 1
        tick(1);
        page_i = 1'b1;
        pin("p1_idx7", 8'h7F, 7'h7F, 1'b1);
        pin("p1_idx5", 8'hDF, 7'b0011001, 1'b0);
        pin("p1_idx0", 8'hFE, 7'b0010000, 1'b1);

        // leading-zero suppression
        tick(1);
        page_i  = 1'b0;
        count_i = 36'h012345678;
        pin("lz_idx7", 8'h7F, 7'h7F, 1'b1);
        pin("lz_idx6", 8'hBF, 7'b1111001, 1'b0);

        // lap freeze and resume
        count_i = 36'h123456789;
        tick(2);
        pulse_lap();
        count_i = 36'h000000001;
        pin("frz_idx0", 8'hFE, 7'b0000000, 1'b0);
        pin("frz_idx7", 8'h7F, 7'b1111001, 1'b1);
        tick(1);
        pulse_lap();
        wait_anode(8'h7F);
        pin("live_idx0", 8'hFE, 7'b1000000, 1'b1);

        // long lap hold toggles only once
        tick(1);
        lap_i = 1'b1;
        tick(20);
        lap_i = 1'b0;
        wait_anode(8'h7F);
        pin("hold_idx0", 8'hFE, 7'b1000000, 1'b0);
        tick(1);
        pulse_lap();

        // dash digit, then reset while frozen mid-scan
        count_i = 36'h1234567A9;
        tick(2);
        pulse_lap();
        wait_anode(8'h7F);
        pin("dash_idx0", 8'hFE, 7'b0111111, 1'b0);
        wait_anode(8'hFB);
        #1;
        resetn_i = 1'b0;
        tick(3);
        resetn_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_anode", 32'(anode_o), 32'hFE);
        chk("post_rst_dp", 32'(dp_o), 32'h1);
        chk("post_rst_seg", 32'(seg_o), 32'h3F);
        #1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 30) page_i = ~page_i;
            if (r >= 100 && r < 160) lap_i = ~lap_i;
            if (r >= 500) begin
                for (int k = 0; k < 9; k++)
                    count_i[k*4 +: 4] = ($urandom_range(0, 19) == 0) ?
                        4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            if (r == 999) begin
                resetn_i = 1'b0;
                tick(int'($urandom_range(1, 3)));
                resetn_i = 1'b1;
            end
            tick(1);
        end

        tick(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
